// File: rtl/dpi_frame_capture.sv
// dpi_frame_capture
//   Captures one frame of Raspberry Pi DPI video into an external byte-wide
//   SRAM pair. Each active pixel is reduced to 6 bits and written with a
//   two-cycle cycle (setup, then we_n strobe). Two SRAM chips are used as
//   ping-pong banks: every completed frame flips the bank.
//
// Ports
//   clk_in                     single clock, rising edge
//   reset                      asynchronous, active-low
//   pix_valid                  one-cycle pixel strobe
//   h_sync_in, v_sync_in       DPI syncs (polarity set by SYNC_LOW)
//   r_in, g_in, b_in [3:0]     pixel colour
//   arm                        one-cycle request to capture the next frame
//   abort                      cancel capture
//   addr [20:0], data_out [7:0], data_oe, we_n, cs_0, cs_1   SRAM side
//   busy                       waiting for vsync or capturing
//   done                       one-cycle frame-complete pulse
//   frame_err, overrun         sticky error flags, cleared by arm
module dpi_frame_capture #(
  parameter int H_START  = 0,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 0,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_LOW = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  input  logic        arm,
  input  logic        abort,
  output logic [20:0] addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        we_n,
  output logic        cs_0,
  output logic        cs_1,
  output logic        busy,
  output logic        done,
  output logic        frame_err,
  output logic        overrun
);

  localparam int   H_END    = H_START + H_ACTIVE;
  localparam int   V_END    = V_START + V_ACTIVE;
  // One spare bit so the saturated all-ones value is always outside the window.
  localparam int   HW       = $clog2(H_END + 1) + 1;
  localparam int   VW       = $clog2(V_END + 1) + 1;
  localparam logic SYNC_INV = (SYNC_LOW != 0);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE} phase_e;

  state_e state_q, state_d;
  phase_e phase_q, phase_d;

  // Registered inputs; syncs are stored already converted to "active" level.
  logic       pv_q;
  logic       hs_act_q, hs_prev_q;
  logic       vs_act_q, vs_prev_q;
  logic [7:0] pix_q;

  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;

  logic [20:0] ptr_q, ptr_d;
  logic [20:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;
  logic        bank_q, bank_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic hs_lead, vs_lead;
  logic pix_active, act_pix, frame_end;
  logic arm_take, start_wr;

  // ---------------------------------------------------------------- inputs
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pv_q      <= 1'b0;
      hs_act_q  <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_act_q  <= 1'b0;
      vs_prev_q <= 1'b0;
      pix_q     <= 8'h00;
    end else begin
      pv_q      <= pix_valid;
      hs_act_q  <= h_sync_in ^ SYNC_INV;
      hs_prev_q <= hs_act_q;
      vs_act_q  <= v_sync_in ^ SYNC_INV;
      vs_prev_q <= vs_act_q;
      pix_q     <= {2'b00, g_in[3:2], b_in[3:2], r_in[3:2]};
    end
  end

  assign hs_lead = hs_act_q & ~hs_prev_q;
  assign vs_lead = vs_act_q & ~vs_prev_q;

  // -------------------------------------------------------- raster counters
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      if (hs_lead) begin
        h_cnt_q <= '0;
      end else if (pv_q && (h_cnt_q != {HW{1'b1}})) begin
        h_cnt_q <= h_cnt_q + HW'(1);
      end
      // vsync wins when both edges coincide so the first line is line 0.
      if (vs_lead) begin
        v_cnt_q <= '0;
      end else if (hs_lead && (v_cnt_q != {VW{1'b1}})) begin
        v_cnt_q <= v_cnt_q + VW'(1);
      end
    end
  end

  assign pix_active = (int'(h_cnt_q) >= H_START) && (int'(h_cnt_q) < H_END) &&
                      (int'(v_cnt_q) >= V_START) && (int'(v_cnt_q) < V_END);
  assign act_pix    = pv_q && pix_active;
  assign frame_end  = (int'(v_cnt_q) >= V_END);
  assign arm_take   = arm && (state_q == IDLE);

  // A new write may start while idle or in the strobe cycle of the previous
  // one; a pixel arriving during setup is the only case that is dropped.
  assign start_wr   = (state_q == CAPTURE) && !abort && act_pix && (phase_q != PH_SETUP);

  // -------------------------------------------------------------- FSM state
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arm) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (abort)        state_d = IDLE;
        else if (vs_lead) state_d = CAPTURE;
      end
      CAPTURE: begin
        // A fresh vsync restarts the frame rather than ending it.
        if (abort)                                              state_d = IDLE;
        else if (frame_end && (phase_q == PH_IDLE) && !vs_lead) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == WAIT_VS) || (state_q == CAPTURE);
    done = (state_q == DONE);
  end

  // ---------------------------------------------------------- write engine
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:   phase_d = start_wr ? PH_SETUP : PH_IDLE;
      // Abort before the strobe cancels the write cleanly; a strobe already
      // on the bus always runs its full cycle.
      PH_SETUP:  phase_d = (abort || (state_q != CAPTURE)) ? PH_IDLE : PH_STROBE;
      PH_STROBE: phase_d = start_wr ? PH_SETUP : PH_IDLE;
      default:   phase_d = PH_IDLE;
    endcase

    oe_d   = (phase_d != PH_IDLE);
    we_n_d = (phase_d != PH_STROBE);
    addr_d = start_wr ? ptr_q : addr_q;
    data_d = start_wr ? pix_q : data_q;

    // The pointer always names the next free location, so a vsync reload
    // takes effect on the next write even with one still in flight.
    ptr_d = ptr_q;
    if (((state_q == WAIT_VS) || (state_q == CAPTURE)) && vs_lead) begin
      ptr_d = '0;
    end else if (start_wr) begin
      ptr_d = ptr_q + 21'd1;
    end

    ferr_d = ferr_q;
    if (arm_take)                                ferr_d = 1'b0;
    else if ((state_q == CAPTURE) && vs_lead)    ferr_d = 1'b1;

    ovr_d = ovr_q;
    if (arm_take)                                                    ovr_d = 1'b0;
    else if ((state_q == CAPTURE) && act_pix && (phase_q == PH_SETUP)) ovr_d = 1'b1;

    bank_d = (state_q == DONE) ? ~bank_q : bank_q;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= 8'h00;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
      bank_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      bank_q  <= bank_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign addr      = addr_q;
  assign data_out  = data_q;
  assign data_oe   = oe_q;
  assign we_n      = we_n_q;
  assign cs_0      = bank_q;
  assign cs_1      = ~bank_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_dpi_frame_capture.sv
// tb_dpi_frame_capture
//   Drives randomized DPI frames into dpi_frame_capture (4x2 active window)
//   and compares the SRAM writes, flags, done pulses and bank selects with a
//   line/pixel-index reference model.
module tb_dpi_frame_capture;

  localparam int HS = 0;
  localparam int HA = 4;
  localparam int VS = 0;
  localparam int VA = 2;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        pix_valid = 1'b0;
  logic        h_sync_in = 1'b1;
  logic        v_sync_in = 1'b1;
  logic [3:0]  r_in = 4'h0, g_in = 4'h0, b_in = 4'h0;
  logic        arm = 1'b0, abort = 1'b0;
  logic [20:0] addr;
  logic [7:0]  data_out;
  logic        data_oe, we_n, cs_0, cs_1, busy, done, frame_err, overrun;

  dpi_frame_capture #(
    .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .SYNC_LOW(1)
  ) dut (
    .clk_in(clk_in), .reset(reset), .pix_valid(pix_valid),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .arm(arm), .abort(abort),
    .addr(addr), .data_out(data_out), .data_oe(data_oe), .we_n(we_n),
    .cs_0(cs_0), .cs_1(cs_1), .busy(busy), .done(done),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  int     n_cmp = 0;
  int     n_fail = 0;
  longint cycle = 0;
  always @(posedge clk_in) cycle++;

  // Bus monitor, sampled on the falling edge.
  logic [20:0] obs_addr[$];
  logic [7:0]  obs_data[$];
  int oe_cycles = 0, oe_viol = 0, done_cnt = 0;
  always @(negedge clk_in) begin
    if (we_n === 1'b0) begin
      obs_addr.push_back(addr);
      obs_data.push_back(data_out);
      if (data_oe !== 1'b1) oe_viol++;
    end
    if (data_oe === 1'b1) oe_cycles++;
    if (done === 1'b1) done_cnt++;
  end

  // Reference model: frame position in lines/pixels since the last syncs.
  bit          m_armed = 0, m_capt = 0, m_ferr = 0, m_ovr = 0, m_bank = 0;
  int          m_line = 0, m_idx = 0, m_done = 0;
  logic [20:0] m_ptr = '0;
  longint      m_last_acc = -10;
  logic [20:0] exp_addr[$];
  logic [7:0]  exp_data[$];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic clear_logs();
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
    oe_cycles = 0; oe_viol = 0;
  endtask

  task automatic do_arm();
    if (!m_armed && !m_capt) begin
      m_armed = 1; m_ferr = 0; m_ovr = 0;
    end
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic pixel(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    bit act;
    int packed_px;
    act = m_capt && (m_line >= VS) && (m_line < VS + VA) && (m_idx >= HS) && (m_idx < HS + HA);
    if (act) begin
      // A write occupies two cycles; a pixel one cycle after an accepted one is lost.
      if (cycle - m_last_acc == 1) begin
        m_ovr = 1;
      end else begin
        packed_px = (int'(r) >> 2) | ((int'(b) >> 2) << 2) | ((int'(g) >> 2) << 4);
        exp_addr.push_back(m_ptr);
        exp_data.push_back(8'(packed_px));
        m_ptr = m_ptr + 21'd1;
        m_last_acc = cycle;
      end
    end
    m_idx++;
    pix_valid = 1'b1; r_in = r; g_in = g; b_in = b;
    cyc(1);
    pix_valid = 1'b0;
  endtask

  task automatic rand_pixel();
    pixel(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
  endtask

  task automatic sync(input bit hs, input bit vs);
    if (vs) begin
      if (m_capt) m_ferr = 1;
      if (m_armed) begin m_armed = 0; m_capt = 1; end
      m_line = 0;
      m_ptr = '0;
    end else if (hs) begin
      m_line++;
    end
    if (hs) m_idx = 0;
    if (m_capt && (m_line >= VS + VA)) begin
      m_capt = 0; m_done++; m_bank = ~m_bank;
    end
    if (hs) h_sync_in = 1'b0;
    if (vs) v_sync_in = 1'b0;
    cyc(2);
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [36:0] obs, expv;
    expv = {21'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    reset = 1'b0;
    cyc(3);
    obs = {addr, data_out, data_oe, we_n, cs_0, cs_1, busy, done, frame_err, overrun};
    n_cmp++;
    if (obs !== expv) begin n_fail++; $display("FAIL reset_held got=%h want=%h", obs, expv); end
    reset = 1'b1;
    cyc(3);
    obs = {addr, data_out, data_oe, we_n, cs_0, cs_1, busy, done, frame_err, overrun};
    n_cmp++;
    if (obs !== expv) begin n_fail++; $display("FAIL reset_released got=%h want=%h", obs, expv); end
    $display("test_reset: outputs checked in and after reset");
  endtask

  task automatic test_basic_frame();
    int d0, m0, n;
    clear_logs();
    d0 = done_cnt; m0 = m_done;
    do_arm();
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_arm got=%b want=1", busy); end
    rand_pixel(); cyc(2); rand_pixel(); cyc(2);   // ignored while waiting for vsync
    sync(1, 1);
    for (int ln = 0; ln < 2; ln++) begin
      n = 4 + $urandom_range(2, 0);
      for (int k = 0; k < n; k++) begin
        if (ln == 0 && k == 0) pixel(4'hC, 4'h8, 4'h4);
        else rand_pixel();
        cyc(2 + $urandom_range(2, 0));
      end
      cyc(2);
      sync(1, 0);
    end
    cyc(10);
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_fail++; $display("FAIL basic_write_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      $display("basic write %0d: addr=%0d data=%02h (model addr=%0d data=%02h)", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL basic_write[%0d] got=%0d/%02h want=%0d/%02h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 != m_done - m0) begin n_fail++; $display("FAIL basic_done_pulses got=%0d want=%0d", done_cnt - d0, m_done - m0); end
    n_cmp++;
    if (cs_0 !== m_bank || cs_1 !== ~m_bank) begin n_fail++; $display("FAIL basic_bank got cs_0=%b cs_1=%b want cs_0=%b", cs_0, cs_1, m_bank); end
    n_cmp++;
    if (oe_cycles != 2 * exp_addr.size()) begin n_fail++; $display("FAIL basic_oe_cycles got=%0d want=%0d", oe_cycles, 2 * exp_addr.size()); end
    n_cmp++;
    if (oe_viol != 0) begin n_fail++; $display("FAIL basic_strobe_without_oe got=%0d want=0", oe_viol); end
    n_cmp++;
    if ({busy, frame_err, overrun} !== {1'b0, m_ferr, m_ovr}) begin
      n_fail++; $display("FAIL basic_flags got busy/ferr/ovr=%b%b%b want=0%b%b", busy, frame_err, overrun, m_ferr, m_ovr);
    end
  endtask

  task automatic test_overrun();
    int d0, m0;
    clear_logs();
    d0 = done_cnt; m0 = m_done;
    do_arm();
    sync(1, 1);
    for (int ln = 0; ln < 2; ln++) begin
      rand_pixel(); rand_pixel();               // back-to-back pair
      for (int k = 0; k < 5; k++) begin
        cyc($urandom_range(2, 0));
        rand_pixel();
      end
      cyc(4);
      sync(1, 0);
    end
    cyc(10);
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_fail++; $display("FAIL ovr_write_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      $display("overrun write %0d: addr=%0d data=%02h (model addr=%0d data=%02h)", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL ovr_write[%0d] got=%0d/%02h want=%0d/%02h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_cmp++;
    if (overrun !== m_ovr) begin n_fail++; $display("FAIL ovr_flag got=%b want=%b", overrun, m_ovr); end
    n_cmp++;
    if (frame_err !== m_ferr) begin n_fail++; $display("FAIL ovr_frame_err got=%b want=%b", frame_err, m_ferr); end
    n_cmp++;
    if (done_cnt - d0 != m_done - m0) begin n_fail++; $display("FAIL ovr_done_pulses got=%0d want=%0d", done_cnt - d0, m_done - m0); end
    n_cmp++;
    if (cs_0 !== m_bank) begin n_fail++; $display("FAIL ovr_bank got=%b want=%b", cs_0, m_bank); end
  endtask

  task automatic test_frame_err();
    int d0, m0;
    clear_logs();
    d0 = done_cnt; m0 = m_done;
    do_arm();
    n_cmp++;
    if ({frame_err, overrun} !== {m_ferr, m_ovr}) begin
      n_fail++; $display("FAIL arm_clears_flags got ferr/ovr=%b%b want=%b%b", frame_err, overrun, m_ferr, m_ovr);
    end
    sync(1, 1);
    for (int k = 0; k < 4; k++) begin rand_pixel(); cyc(2 + $urandom_range(1, 0)); end
    cyc(3);
    sync(1, 1);                                 // premature vsync restarts the frame
    for (int ln = 0; ln < 2; ln++) begin
      for (int k = 0; k < 4; k++) begin rand_pixel(); cyc(2 + $urandom_range(1, 0)); end
      cyc(3);
      sync(1, 0);
    end
    cyc(10);
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_fail++; $display("FAIL ferr_write_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      $display("frame_err write %0d: addr=%0d data=%02h (model addr=%0d data=%02h)", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL ferr_write[%0d] got=%0d/%02h want=%0d/%02h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_cmp++;
    if (frame_err !== m_ferr) begin n_fail++; $display("FAIL ferr_flag got=%b want=%b", frame_err, m_ferr); end
    n_cmp++;
    if (done_cnt - d0 != m_done - m0) begin n_fail++; $display("FAIL ferr_done_pulses got=%0d want=%0d", done_cnt - d0, m_done - m0); end
    n_cmp++;
    if (cs_0 !== m_bank) begin n_fail++; $display("FAIL ferr_bank got=%b want=%b", cs_0, m_bank); end
  endtask

  task automatic test_abort();
    int d0, m0;
    clear_logs();
    d0 = done_cnt; m0 = m_done;
    do_arm();
    sync(1, 1);
    rand_pixel();
    cyc(2);                                     // now in the strobe cycle
    n_cmp++;
    if (we_n !== 1'b0) begin n_fail++; $display("FAIL abort_strobe_present got we_n=%b want=0", we_n); end
    abort = 1'b1; m_capt = 0; m_armed = 0;
    cyc(1);
    abort = 1'b0;
    n_cmp++;
    if ({we_n, data_oe, busy} !== 3'b100) begin
      n_fail++; $display("FAIL abort_after got we_n/oe/busy=%b%b%b want=100", we_n, data_oe, busy);
    end
    for (int k = 0; k < 3; k++) begin rand_pixel(); cyc(3); end
    sync(1, 0);
    cyc(10);
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_fail++; $display("FAIL abort_write_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      $display("abort write %0d: addr=%0d data=%02h (model addr=%0d data=%02h)", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL abort_write[%0d] got=%0d/%02h want=%0d/%02h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 != m_done - m0) begin n_fail++; $display("FAIL abort_done_pulses got=%0d want=%0d", done_cnt - d0, m_done - m0); end
    n_cmp++;
    if (cs_0 !== m_bank) begin n_fail++; $display("FAIL abort_bank got=%b want=%b", cs_0, m_bank); end
  endtask

  task automatic test_reset_mid_write();
    logic [36:0] obs, expv;
    int d0;
    clear_logs();
    do_arm();
    sync(1, 1);
    rand_pixel();
    cyc(1);                                     // now in the setup cycle
    n_cmp++;
    if ({data_oe, we_n} !== 2'b11) begin n_fail++; $display("FAIL midwrite_setup got oe/we_n=%b%b want=11", data_oe, we_n); end
    #2;
    reset = 1'b0;
    m_armed = 0; m_capt = 0; m_ferr = 0; m_ovr = 0; m_bank = 0;
    exp_addr.delete(); exp_data.delete();
    #1;
    expv = {21'd0, 8'd0, 1'b0, 1'b1, m_bank, ~m_bank, 1'b0, 1'b0, m_ferr, m_ovr};
    obs = {addr, data_out, data_oe, we_n, cs_0, cs_1, busy, done, frame_err, overrun};
    n_cmp++;
    if (obs !== expv) begin n_fail++; $display("FAIL midwrite_async_reset got=%h want=%h", obs, expv); end
    d0 = done_cnt;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    sync(1, 1);
    for (int k = 0; k < 3; k++) begin rand_pixel(); cyc(3); end
    cyc(10);
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_fail++; $display("FAIL midwrite_writes_after_reset got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end
    n_cmp++;
    if ({busy, cs_0} !== {1'b0, m_bank} || done_cnt != d0) begin
      n_fail++; $display("FAIL midwrite_idle_after got busy=%b cs_0=%b done_pulses=%0d want busy=0 cs_0=%b done_pulses=0", busy, cs_0, done_cnt - d0, m_bank);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_frame_err();
    test_abort();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
